// File: rtl/bellek_yanitlayici.sv
// Word-addressed memory that responds to the processor's single-port bus.
// After reset it zeroes itself, then serves combinational reads and clocked writes.
module bellek_yanitlayici #(
    parameter int                  ADRES_BIT     = 32,
    parameter int                  VERI_BIT      = 32,
    parameter int                  BELLEK_SOZCUK = 256,
    parameter logic [ADRES_BIT-1:0] BELLEK_ADRES = 32'h8000_0000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ADRES_BIT-1:0] bellek_adres,
    input  logic [VERI_BIT-1:0]  bellek_yaz_veri,
    input  logic                 bellek_yaz,
    output logic [VERI_BIT-1:0]  bellek_oku_veri,
    output logic                 hazir,
    output logic                 adres_hata,
    output logic [15:0]          yazma_sayaci
);

    localparam int                   IDX_W = $clog2(BELLEK_SOZCUK);
    localparam logic [ADRES_BIT-1:0] SINIR = ADRES_BIT'(4 * BELLEK_SOZCUK);
    localparam logic [IDX_W-1:0]     SON   = IDX_W'(BELLEK_SOZCUK - 1);

    typedef enum logic {TEMIZLE, HAZIR} durum_t;

    durum_t             durum_q, durum_d;
    logic [IDX_W-1:0]   temizle_idx_q, temizle_idx_d;
    logic               adres_hata_q, adres_hata_d;
    logic [15:0]        sayac_q, sayac_d;

    logic [VERI_BIT-1:0] mem [BELLEK_SOZCUK];

    logic [ADRES_BIT-1:0] ofset;
    logic                 yasal;
    logic [IDX_W-1:0]     idx;
    logic                 yaz_kabul;

    // Addresses below the base wrap to a huge offset and fall out of range.
    assign ofset     = bellek_adres - BELLEK_ADRES;
    assign yasal     = (ofset[1:0] == 2'b00) && (ofset < SINIR);
    assign idx       = ofset[IDX_W+1:2];
    assign hazir     = (durum_q == HAZIR);
    assign yaz_kabul = hazir && bellek_yaz && yasal;

    always_comb begin
        durum_d       = durum_q;
        temizle_idx_d = temizle_idx_q;
        adres_hata_d  = adres_hata_q;
        sayac_d       = sayac_q;
        case (durum_q)
            TEMIZLE: begin
                temizle_idx_d = temizle_idx_q + 1'b1;
                if (temizle_idx_q == SON) durum_d = HAZIR;
            end
            HAZIR: begin
                if (!yasal) adres_hata_d = 1'b1;
                if (yaz_kabul && (sayac_q != 16'hFFFF)) sayac_d = sayac_q + 16'd1;
            end
            default: durum_d = TEMIZLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            durum_q       <= TEMIZLE;
            temizle_idx_q <= '0;
            adres_hata_q  <= 1'b0;
            sayac_q       <= '0;
        end else begin
            durum_q       <= durum_d;
            temizle_idx_q <= temizle_idx_d;
            adres_hata_q  <= adres_hata_d;
            sayac_q       <= sayac_d;
        end
    end

    // Array has no reset; the clear sequence owns the write port until done.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (durum_q == TEMIZLE)  mem[temizle_idx_q] <= '0;
            else if (yaz_kabul)      mem[idx] <= bellek_yaz_veri;
        end
    end

    assign bellek_oku_veri = (hazir && yasal) ? mem[idx] : '0;
    assign adres_hata      = adres_hata_q;
    assign yazma_sayaci    = sayac_q;

endmodule

// File: tb/tb_bellek_yanitlayici.sv
// Directed bench for bellek_yanitlayici: a behavioural model checked every
// negedge, plus literal expectations for the key scenarios.
module tb_bellek_yanitlayici;

    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam int          N    = 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] bellek_adres = BASE;
    logic [31:0] bellek_yaz_veri = 32'hFFFF_FFFF;
    logic        bellek_yaz = 1'b1;
    logic [31:0] bellek_oku_veri;
    logic        hazir;
    logic        adres_hata;
    logic [15:0] yazma_sayaci;

    int tests = 0;
    int fails = 0;

    bellek_yanitlayici dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .bellek_adres    (bellek_adres),
        .bellek_yaz_veri (bellek_yaz_veri),
        .bellek_yaz      (bellek_yaz),
        .bellek_oku_veri (bellek_oku_veri),
        .hazir           (hazir),
        .adres_hata      (adres_hata),
        .yazma_sayaci    (yazma_sayaci)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 40) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    int          m_edges = 0;
    logic        m_err   = 1'b0;
    int          m_cnt   = 0;
    logic [31:0] m_mem [N];

    function automatic bit legal(input logic [31:0] a);
        logic [31:0] o;
        o = a - BASE;
        return (o % 4 == 0) && (o < 4 * N);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) / 4);
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (m_edges >= N && legal(a)) return m_mem[widx(a)];
        return 32'h0;
    endfunction

    always @(negedge rst_n) begin
        m_edges = 0;
        m_err   = 1'b0;
        m_cnt   = 0;
    end

    always @(posedge clk) begin
        if (rst_n) begin
            if (m_edges < N) begin
                m_edges++;
                if (m_edges == N) for (int i = 0; i < N; i++) m_mem[i] = 32'h0;
            end else if (!legal(bellek_adres)) begin
                m_err = 1'b1;
            end else if (bellek_yaz) begin
                m_mem[widx(bellek_adres)] = bellek_yaz_veri;
                if (m_cnt < 65535) m_cnt++;
            end
        end
    end

    always @(negedge clk) begin
        chk("m_oku",   bellek_oku_veri, m_read(bellek_adres));
        chk("m_hazir", {31'h0, hazir}, {31'h0, (m_edges >= N)});
        chk("m_hata",  {31'h0, adres_hata}, {31'h0, m_err});
        chk("m_sayac", {16'h0, yazma_sayaci}, 32'(m_cnt));
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts edges after the current point until hazir is seen; drops bellek_yaz at once.
    task automatic wait_ready(output int n);
        n = 0;
        while (!hazir && n < 1000) begin
            step();
            n++;
        end
        bellek_yaz = 1'b0;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic w);
        bellek_adres    = a;
        bellek_yaz_veri = d;
        bellek_yaz      = w;
    endtask

    initial begin
        int n;
        // Reset, then clear with a write strobe held the whole time.
        #3;
        chk("rst_hazir", {31'h0, hazir}, 32'h0);
        chk("rst_hata",  {31'h0, adres_hata}, 32'h0);
        chk("rst_sayac", {16'h0, yazma_sayaci}, 32'h0);
        chk("rst_oku",   bellek_oku_veri, 32'h0);
        step(); step();
        rst_n = 1'b1;
        wait_ready(n);
        chk("clear_edges", 32'(n), 32'd256);
        #1;
        chk("clear_w0", bellek_oku_veri, 32'h0);
        chk("clear_sayac", {16'h0, yazma_sayaci}, 32'h0);
        chk("clear_hata", {31'h0, adres_hata}, 32'h0);
        drive(32'h8000_03FC, 32'h0, 1'b0); #1;
        chk("clear_last", bellek_oku_veri, 32'h0);

        // Write then read back.
        step();
        drive(32'h8000_0010, 32'hCAFE_1234, 1'b1); #1;
        chk("wr_same_cycle", bellek_oku_veri, 32'h0);
        step();
        bellek_yaz = 1'b0; #1;
        chk("wr_readback", bellek_oku_veri, 32'hCAFE_1234);
        chk("wr_sayac", {16'h0, yazma_sayaci}, 32'd1);

        // Illegal accesses.
        step();
        drive(32'h8000_0400, 32'h0, 1'b0); #1;
        chk("ill_oob_oku", bellek_oku_veri, 32'h0);
        step();
        chk("ill_hata1", {31'h0, adres_hata}, 32'h1);
        drive(32'h8000_0002, 32'h1111_1111, 1'b1); #1;
        chk("ill_mis_oku", bellek_oku_veri, 32'h0);
        step();
        drive(32'h7FFF_FFFC, 32'h0, 1'b0); #1;
        chk("ill_low_oku", bellek_oku_veri, 32'h0);
        step();
        drive(32'h8000_0010, 32'h0, 1'b0); #1;
        chk("ill_hata_sticky", {31'h0, adres_hata}, 32'h1);
        chk("ill_sayac", {16'h0, yazma_sayaci}, 32'd1);
        chk("ill_mem_ok", bellek_oku_veri, 32'hCAFE_1234);
        drive(32'h8000_0000, 32'h0, 1'b0); #1;
        chk("ill_mem_w0", bellek_oku_veri, 32'h0);

        // Reset in the middle of the clear.
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) step();
        chk("mid_hazir_low", {31'h0, hazir}, 32'h0);
        rst_n = 1'b0;
        step();
        chk("mid_hata_clr", {31'h0, adres_hata}, 32'h0);
        rst_n = 1'b1;
        wait_ready(n);
        chk("mid_edges", 32'(n), 32'd256);

        // Saturating write counter.
        for (int i = 0; i < 65537; i++) begin
            drive(BASE + 32'((i % N) * 4), 32'(i), 1'b1);
            step();
        end
        bellek_yaz = 1'b0;
        drive(BASE, 32'h0, 1'b0); #1;
        chk("sat_sayac", {16'h0, yazma_sayaci}, 32'h0000_FFFF);
        chk("sat_w0", bellek_oku_veri, 32'h0001_0000);
        drive(32'h8000_0020, 32'hA5A5_A5A5, 1'b1);
        step();
        bellek_yaz = 1'b0; #1;
        chk("sat_hold", {16'h0, yazma_sayaci}, 32'h0000_FFFF);
        chk("sat_wr", bellek_oku_veri, 32'hA5A5_A5A5);

        step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
